io_out_block: RTL



---
 rtl/io_out_block_if.sv | 21 ++
 rtl/io_out_block.sv | 104 ++++++++++
 2 files changed

// File: rtl/io_out_block_if.sv
// Serial configuration-chain bundle for io_out_block: shift data, commit/capture requests and status.
// The master side drives the chain; the cell itself is the slave.
interface io_out_block_if;
    logic cfg_sin;
    logic cfg_en;
    logic cfg_commit;
    logic cfg_capture;
    logic cfg_sout;
    logic cfg_done;
    logic cfg_err;

    modport master (
        output cfg_sin, cfg_en, cfg_commit, cfg_capture,
        input  cfg_sout, cfg_done, cfg_err
    );

    modport slave (
        input  cfg_sin, cfg_en, cfg_commit, cfg_capture,
        output cfg_sout, cfg_done, cfg_err
    );
endinterface

// File: rtl/io_out_block.sv
// Output IO cell: drives one pad from a selectable fabric track via a shadow/active config pair.
// Define IO_OUT_READBACK_EN to let cfg_capture copy the active config back into the shift chain.
module io_out_block #(
    parameter int N_TRACKS = 3,
    parameter int SEL_W    = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    io_out_block_if.slave       cfg,
    input  logic [N_TRACKS-1:0] fabric_in,
    input  logic                fabric_ce,
    inout  wire                 pad
);
    localparam int CFG_W = SEL_W + 3;
    localparam int CNT_W = $clog2(CFG_W + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CFG_W);

    logic [CFG_W-1:0] shadow_q, shadow_d;
    logic [CFG_W-1:0] active_q, active_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             out_q, out_d;

    logic [SEL_W-1:0]    sel;
    logic                oe;
    logic                reg_mode;
    logic                invert;
    logic [N_TRACKS-1:0] hit;
    logic                src;
    logic                val;
    logic                drive;

    always_comb begin
        shadow_d = shadow_q;
        active_d = active_q;
        count_d  = count_q;
        err_d    = 1'b0;
        // A commit request always takes priority; any simultaneous shift is dropped.
        if (cfg.cfg_commit) begin
            if (done_q) begin
                active_d = shadow_q;
                count_d  = '0;
            end else begin
                err_d = 1'b1;
            end
        end else if (cfg.cfg_en) begin
            shadow_d = {cfg.cfg_sin, shadow_q[CFG_W-1:1]};
            if (count_q != CNT_FULL) begin
                count_d = count_q + CNT_W'(1);
            end
        end
`ifdef IO_OUT_READBACK_EN
        else if (cfg.cfg_capture) begin
            shadow_d = active_q;
            count_d  = CNT_FULL;
        end
`endif
        done_d = (count_d == CNT_FULL);
    end

`ifndef IO_OUT_READBACK_EN
    logic unused_capture;
    assign unused_capture = cfg.cfg_capture;
`endif

    assign sel      = active_q[SEL_W-1:0];
    assign oe       = active_q[SEL_W];
    assign reg_mode = active_q[SEL_W+1];
    assign invert   = active_q[SEL_W+2];

    // Out-of-range selects match no track, so src falls back to 0.
    for (genvar gi = 0; gi < N_TRACKS; gi++) begin : g_track
        assign hit[gi] = fabric_in[gi] & (sel == SEL_W'(gi));
    end

    assign src   = |hit;
    assign val   = src ^ invert;
    assign out_d = fabric_ce ? val : out_q;
    assign drive = reg_mode ? out_q : val;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q <= '0;
            active_q <= '0;
            count_q  <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            out_q    <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            active_q <= active_d;
            count_q  <= count_d;
            done_q   <= done_d;
            err_q    <= err_d;
            out_q    <= out_d;
        end
    end

    assign cfg.cfg_sout = shadow_q[0];
    assign cfg.cfg_done = done_q;
    assign cfg.cfg_err  = err_q;
    assign pad          = oe ? drive : 1'bz;
endmodule
